// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive channel.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    // Parity mode encodings.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Given the XOR of all data bits and the received parity bit, report a mismatch.
    // Even mode requires the total XOR to be 0, odd mode requires it to be 1.
    function automatic logic par_mismatch(input logic xor_all, input int mode);
        if (mode == PAR_EVEN) begin
            return xor_all;
        end else begin
            return ~xor_all;
        end
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look like activity.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock_out,
    input  logic nreset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous input, then re-register to settle metastability.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop frame, LSB first, sampled at
// bit centres on an oversampled clock. Delivers bytes on valid/ready and pulses
// framing, parity and overrun errors for one cycle each.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BYTESIZES    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY       = 0
) (
    input  logic                 clock_out,
    input  logic                 nreset,
    input  logic                 sdata_rx_in,
    input  logic                 ready_rx_in,
    output logic [BYTESIZES-1:0] data_rx_out,
    output logic                 valid_rx_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 overrun_err_out
);

    localparam int P  = (PARITY != PAR_NONE) ? 1 : 0;
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(BYTESIZES + 1);

    // Half a bit from the falling edge lands on the start-bit centre; a full bit
    // from there lands on every following bit centre.
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BYTESIZES - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [BYTESIZES-1:0] r_shift;
    logic                 r_par_mis;
    logic [BYTESIZES-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun_err;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clock_out(clock_out),
        .nreset   (nreset),
        .i_async  (sdata_rx_in),
        .o_sync   (w_rx_s)
    );

    // Frame FSM with the output register, handshake and error pulses.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_par_mis     <= 1'b0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;

            // Consumer accept; a commit on this same edge overrides below.
            if (r_valid && ready_rx_in) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s == 1'b0) begin
                        r_state <= START;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_s == 1'b0) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_par_mis <= 1'b0;
                        end else begin
                            // Too short to be a start bit: treat as line noise.
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + BW'(1);
                        for (int i = 0; i < BYTESIZES; i++) begin
                            if (r_bit_idx == BW'(i)) begin
                                r_shift[i] <= w_rx_s;
                            end
                        end
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= (P != 0) ? PAR : STOP;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                PAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_mis <= par_mismatch((^r_shift) ^ w_rx_s, PARITY);
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s == 1'b1) begin
                            r_data        <= r_shift;
                            r_valid       <= 1'b1;
                            r_parity_err  <= r_par_mis;
                            // Unconsumed byte replaced without an accept this edge.
                            r_overrun_err <= r_valid && !ready_rx_in;
                            r_state       <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s == 1'b1) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= BREAK;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_rx_out     = r_data;
    assign valid_rx_out    = r_valid;
    assign frame_err_out   = r_frame_err;
    assign parity_err_out  = r_parity_err;
    assign overrun_err_out = r_overrun_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no parity, odd, even) driven with directed
// and random frames; expectations come from the frame contents and timing rules.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       nreset;
    logic       line    [3];
    logic       ready   [3];
    logic [7:0] data_o  [3];
    logic       valid_o [3];
    logic       ferr_o  [3];
    logic       perr_o  [3];
    logic       ovr_o   [3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Event counters maintained by the monitor.
    int         n_acc    [3] = '{default: 0};
    int         n_rise   [3] = '{default: 0};
    int         n_ferr   [3] = '{default: 0};
    int         n_perr   [3] = '{default: 0};
    int         n_ovr    [3] = '{default: 0};
    int         rise_cyc [3] = '{default: 0};
    int         fall_cyc [3] = '{default: 0};
    logic [7:0] last_acc [3] = '{default: 8'h00};
    logic       prev_v   [3] = '{default: 1'b0};

    // Snapshots taken by the main thread before each scenario.
    int b_acc [3];
    int b_rise[3];
    int b_ferr[3];
    int b_perr[3];
    int b_ovr [3];

    uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS), .PARITY(0)) u_dut0 (
        .clock_out(clk), .nreset(nreset), .sdata_rx_in(line[0]), .ready_rx_in(ready[0]),
        .data_rx_out(data_o[0]), .valid_rx_out(valid_o[0]), .frame_err_out(ferr_o[0]),
        .parity_err_out(perr_o[0]), .overrun_err_out(ovr_o[0]));

    uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS), .PARITY(1)) u_dut1 (
        .clock_out(clk), .nreset(nreset), .sdata_rx_in(line[1]), .ready_rx_in(ready[1]),
        .data_rx_out(data_o[1]), .valid_rx_out(valid_o[1]), .frame_err_out(ferr_o[1]),
        .parity_err_out(perr_o[1]), .overrun_err_out(ovr_o[1]));

    uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS), .PARITY(2)) u_dut2 (
        .clock_out(clk), .nreset(nreset), .sdata_rx_in(line[2]), .ready_rx_in(ready[2]),
        .data_rx_out(data_o[2]), .valid_rx_out(valid_o[2]), .frame_err_out(ferr_o[2]),
        .parity_err_out(perr_o[2]), .overrun_err_out(ovr_o[2]));

    // Clock generation.
    always #5 clk = ~clk;

    // Posedge counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts accepts, valid edges and error pulses mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_o[k] && ready[k]) begin
                n_acc[k]++;
                last_acc[k] = data_o[k];
            end
            if (valid_o[k] && !prev_v[k]) begin
                n_rise[k]++;
                rise_cyc[k] = cyc;
            end
            if (!valid_o[k] && prev_v[k]) fall_cyc[k] = cyc;
            if (ferr_o[k]) n_ferr[k]++;
            if (perr_o[k]) n_perr[k]++;
            if (ovr_o[k])  n_ovr[k]++;
            prev_v[k] = valid_o[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n posedges and land just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int k, input logic v, input int n);
        line[k] = v;
        tick(n);
    endtask

    // Parity bit a correct transmitter would send for this byte and mode.
    function automatic logic good_par(input logic [7:0] d, input int mode);
        int ones;
        ones = $countones(d);
        if (mode == 2) return logic'(ones % 2);
        return logic'(1 - (ones % 2));
    endfunction

    // Instance k uses parity mode k (0 none, 1 odd, 2 even).
    task automatic send(input int k, input logic [7:0] d, input logic pflip,
                        input logic stop_ok, input int extra_low);
        hold(k, 1'b0, OS);
        for (int i = 0; i < 8; i++) hold(k, d[i], OS);
        if (k != 0) hold(k, good_par(d, k) ^ pflip, OS);
        if (stop_ok) begin
            hold(k, 1'b1, OS);
        end else begin
            hold(k, 1'b0, OS + extra_low);
            line[k] = 1'b1;
        end
    endtask

    task automatic snap();
        for (int k = 0; k < 3; k++) begin
            b_acc[k]  = n_acc[k];
            b_rise[k] = n_rise[k];
            b_ferr[k] = n_ferr[k];
            b_perr[k] = n_perr[k];
            b_ovr[k]  = n_ovr[k];
        end
    endtask

    task automatic expect_frame(input int k, input string tag, input int acc, input logic [7:0] d,
                                input int ferr, input int perr, input int ovr);
        chk({tag, "_acc"},  n_acc[k]  - b_acc[k],  acc);
        chk({tag, "_rise"}, n_rise[k] - b_rise[k], acc);
        if (acc > 0) chk({tag, "_data"}, last_acc[k], d);
        chk({tag, "_ferr"}, n_ferr[k] - b_ferr[k], ferr);
        chk({tag, "_perr"}, n_perr[k] - b_perr[k], perr);
        chk({tag, "_ovr"},  n_ovr[k]  - b_ovr[k],  ovr);
    endtask

    initial begin
        int         t0;
        int         k;
        logic [7:0] d;
        logic       flip;
        logic       sok;
        int         extra;
        int         gap;

        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            line[i]  = 1'b1;
            ready[i] = 1'b1;
        end
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk("reset_data",  data_o[i], 8'h00);
            chk("reset_valid", valid_o[i], 1'b0);
            chk("reset_errs",  {ferr_o[i], perr_o[i], ovr_o[i]}, 3'b000);
        end
        nreset = 1'b1;
        tick(5);

        // Exact latency and one-cycle valid with ready held high.
        snap();
        t0 = cyc + 1;
        send(0, 8'hA5, 1'b0, 1'b1, 0);
        tick(4);
        expect_frame(0, "a5", 1, 8'hA5, 0, 0, 0);
        chk("a5_latency", rise_cyc[0] - t0, 154);
        chk("a5_width", fall_cyc[0] - rise_cyc[0], 1);

        // Short low glitch must be ignored; the next frame still arrives.
        snap();
        hold(0, 1'b0, 6);
        hold(0, 1'b1, 20);
        send(0, 8'h3C, 1'b0, 1'b1, 0);
        tick(4);
        expect_frame(0, "glitch", 1, 8'h3C, 0, 0, 0);

        // Framing error, long break, then recovery.
        snap();
        send(0, 8'h81, 1'b0, 1'b0, 40);
        tick(10);
        chk("brk_noacc", n_acc[0] - b_acc[0], 0);
        send(0, 8'h55, 1'b0, 1'b1, 0);
        tick(4);
        expect_frame(0, "brk", 1, 8'h55, 1, 0, 0);

        // Overrun: two frames while the consumer stalls.
        ready[0] = 1'b0;
        snap();
        send(0, 8'h12, 1'b0, 1'b1, 0);
        send(0, 8'h34, 1'b0, 1'b1, 0);
        tick(4);
        chk("ovr_pulse", n_ovr[0] - b_ovr[0], 1);
        @(negedge clk);
        chk("ovr_hold_data", data_o[0], 8'h34);
        chk("ovr_hold_valid", valid_o[0], 1'b1);
        tick(1);
        ready[0] = 1'b1;
        tick(3);
        expect_frame(0, "ovr", 1, 8'h34, 0, 0, 1);

        // Even parity: wrong bit flagged but byte delivered; right bit clean.
        snap();
        send(2, 8'h07, 1'b1, 1'b1, 0);
        tick(4);
        expect_frame(2, "perr_bad", 1, 8'h07, 0, 1, 0);
        snap();
        send(2, 8'h07, 1'b0, 1'b1, 0);
        tick(4);
        expect_frame(2, "perr_ok", 1, 8'h07, 0, 0, 0);

        // Reset during data bit 4 with an unconsumed byte pending.
        ready[0] = 1'b0;
        send(0, 8'h5A, 1'b0, 1'b1, 0);
        tick(2);
        chk("rst_pre_valid", valid_o[0], 1'b1);
        d = 8'hC3;
        hold(0, 1'b0, OS);
        for (int i = 0; i < 4; i++) hold(0, d[i], OS);
        hold(0, d[4], 8);
        nreset = 1'b0;
        #1;
        chk("rst_data",  data_o[0], 8'h00);
        chk("rst_valid", valid_o[0], 1'b0);
        chk("rst_errs",  {ferr_o[0], perr_o[0], ovr_o[0]}, 3'b000);
        line[0] = 1'b1;
        tick(4);
        nreset = 1'b1;
        tick(4);
        ready[0] = 1'b1;
        snap();
        send(0, 8'hC3, 1'b0, 1'b1, 0);
        tick(4);
        expect_frame(0, "rst_after", 1, 8'hC3, 0, 0, 0);

        // Random frames across all parity modes.
        for (int f = 0; f < 30; f++) begin
            k     = int'($urandom_range(0, 2));
            d     = 8'($urandom);
            flip  = (k != 0) && ($urandom_range(0, 3) == 0);
            sok   = ($urandom_range(0, 6) != 0);
            extra = int'($urandom_range(0, 40));
            gap   = int'($urandom_range(1, 20));
            snap();
            send(k, d, flip, sok, extra);
            hold(k, 1'b1, gap);
            expect_frame(k, "rnd", sok ? 1 : 0, d, sok ? 0 : 1, (sok && flip) ? 1 : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
